// File: rtl/kamus_wb_unit.sv
// MEM/WB write-back unit: source select, load align/extend, L1D stall FSM.
// Optional 64-bit retired-instruction counter enabled by KAMUS_WB_RETIRE_CNT_EN.
module kamus_wb_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC),
  parameter int unsigned OFS_W   = $clog2(XLEN / 8)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  input  logic                    regfile_wr_en_i,
  input  logic [4:0]              rd_addr_i,
  input  logic [SEL_W-1:0]        wb_mux_sel_i,
  input  logic [NUM_SRC*XLEN-1:0] src_data_i,
  input  logic [1:0]              ld_size_i,
  input  logic                    ld_unsigned_i,
  input  logic [OFS_W-1:0]        ld_offset_i,
  input  logic                    l1d_rsp_valid_i,
  input  logic [XLEN-1:0]         l1d_rd_data_i,
  output logic                    regfile_wr_en_o,
  output logic [4:0]              rd_addr_o,
  output logic [XLEN-1:0]         wb_data_o,
  output logic                    retire_o
`ifdef KAMUS_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]             retire_cnt_o
`endif
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q, state_d;

  logic             accept;
  logic             is_load;
  logic [XLEN-1:0]  sel_data;

  logic             commit;
  logic             latch_pend;
  logic [4:0]       c_rd;
  logic             c_wr_en;
  logic [XLEN-1:0]  c_data;

  logic [4:0]       pend_rd_q;
  logic             pend_wr_en_q;
  logic [1:0]       pend_size_q;
  logic             pend_unsigned_q;
  logic [OFS_W-1:0] pend_offset_q;

  logic             wr_en_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  data_q;
  logic             retire_q;

  // Shift the addressed bytes down, mask to the access size, then sign-fill.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0]  data,
                                               input logic [1:0]       size,
                                               input logic             uns,
                                               input logic [OFS_W-1:0] ofs);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;
    shifted = data >> {ofs, 3'b000};
    unique case (size)
      2'd0: begin
        mask = XLEN'(8'hFF);
        sign = shifted[7];
      end
      2'd1: begin
        mask = XLEN'(16'hFFFF);
        sign = shifted[15];
      end
      2'd2: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = shifted[XLEN-1];
      end
    endcase
    load_ext = shifted & mask;
    if (!uns && sign) begin
      load_ext = load_ext | ~mask;
    end
  endfunction

  assign ready_o = (state_q == StIdle);
  assign accept  = valid_i && ready_o && !flush_i;
  assign is_load = (wb_mux_sel_i == SEL_W'(1));

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (wb_mux_sel_i == SEL_W'(k)) begin
        sel_data = src_data_i[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && is_load && !l1d_rsp_valid_i) state_d = StWait;
      StWait: if (l1d_rsp_valid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    commit     = 1'b0;
    latch_pend = 1'b0;
    c_rd       = rd_addr_i;
    c_wr_en    = regfile_wr_en_i;
    c_data     = sel_data;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_load) begin
            commit = 1'b1;
          end else if (l1d_rsp_valid_i) begin
            commit = 1'b1;
            c_data = load_ext(l1d_rd_data_i, ld_size_i, ld_unsigned_i, ld_offset_i);
          end else begin
            latch_pend = 1'b1;
          end
        end
      end
      StWait: begin
        if (l1d_rsp_valid_i) begin
          commit  = 1'b1;
          c_rd    = pend_rd_q;
          c_wr_en = pend_wr_en_q;
          c_data  = load_ext(l1d_rd_data_i, pend_size_q, pend_unsigned_q, pend_offset_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_rd_q       <= '0;
      pend_wr_en_q    <= 1'b0;
      pend_size_q     <= '0;
      pend_unsigned_q <= 1'b0;
      pend_offset_q   <= '0;
    end else if (latch_pend) begin
      pend_rd_q       <= rd_addr_i;
      pend_wr_en_q    <= regfile_wr_en_i;
      pend_size_q     <= ld_size_i;
      pend_unsigned_q <= ld_unsigned_i;
      pend_offset_q   <= ld_offset_i;
    end
  end

  // x0 is never written, but the instruction still retires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q  <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      retire_q <= 1'b0;
    end else begin
      wr_en_q  <= commit && c_wr_en && (c_rd != 5'd0);
      retire_q <= commit;
      if (commit) begin
        rd_q   <= c_rd;
        data_q <= c_data;
      end
    end
  end

  assign regfile_wr_en_o = wr_en_q;
  assign rd_addr_o       = rd_q;
  assign wb_data_o       = data_q;
  assign retire_o        = retire_q;

`ifdef KAMUS_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Updates in the same edge as the retire_o pulse it counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_cnt_q <= '0;
    end else if (commit) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_kamus_wb_unit.sv
// Self-checking bench for kamus_wb_unit: vector table plus stall/reset sequences,
// all write-backs checked against a cycle-stamped scoreboard.
module tb_kamus_wb_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned OFS_W   = 2;

  localparam logic [31:0] AluVal = 32'h1234_5678;
  localparam logic [31:0] MemVal = 32'hDEAD_0001;
  localparam logic [31:0] Pc4Val = 32'h0000_1004;
  localparam logic [31:0] CsrVal = 32'hC5C5_0300;

  logic                    clk;
  logic                    rst_n;
  logic                    valid;
  logic                    ready;
  logic                    flush;
  logic                    wr_en_in;
  logic [4:0]              rd_in;
  logic [SEL_W-1:0]        sel;
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic [1:0]              ld_size;
  logic                    ld_uns;
  logic [OFS_W-1:0]        ld_ofs;
  logic                    rsp_valid;
  logic [XLEN-1:0]         rsp_data;
  logic                    wr_en_out;
  logic [4:0]              rd_out;
  logic [XLEN-1:0]         wb_data;
  logic                    retire;
`ifdef KAMUS_WB_RETIRE_CNT_EN
  logic [63:0]             retire_cnt;
`endif

  kamus_wb_unit #(
    .XLEN    (XLEN),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W),
    .OFS_W   (OFS_W)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .valid_i         (valid),
    .ready_o         (ready),
    .flush_i         (flush),
    .regfile_wr_en_i (wr_en_in),
    .rd_addr_i       (rd_in),
    .wb_mux_sel_i    (sel),
    .src_data_i      (src_data),
    .ld_size_i       (ld_size),
    .ld_unsigned_i   (ld_uns),
    .ld_offset_i     (ld_ofs),
    .l1d_rsp_valid_i (rsp_valid),
    .l1d_rd_data_i   (rsp_data),
    .regfile_wr_en_o (wr_en_out),
    .rd_addr_o       (rd_out),
    .wb_data_o       (wb_data),
    .retire_o        (retire)
`ifdef KAMUS_WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o    (retire_cnt)
`endif
  );

  typedef struct {
    logic        flush;
    logic        wr;
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  ofs;
    logic        rsp;
    logic [31:0] l1d;
    logic        exp_wr;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.due  = cyc + 1;
    e.wr   = wr;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  // Every write-back must land exactly on its due cycle with the expected content.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (retire !== 1'b1 || wr_en_out !== e.wr || rd_out !== e.rd || wb_data !== e.data) begin
          errors++;
          $display("FAIL wb@%0d: got ret=%b wr=%b rd=%0d data=0x%h expected ret=1 wr=%b rd=%0d data=0x%h",
                   cyc, retire, wr_en_out, rd_out, wb_data, e.wr, e.rd, e.data);
        end
      end else if (retire !== 1'b0 || wr_en_out !== 1'b0) begin
        errors++;
        $display("FAIL spurious_wb@%0d: got ret=%b wr=%b expected ret=0 wr=0",
                 cyc, retire, wr_en_out);
      end
    end
  end

  task automatic idle_inputs();
    valid     = 1'b0;
    flush     = 1'b0;
    wr_en_in  = 1'b0;
    rd_in     = '0;
    sel       = '0;
    ld_size   = '0;
    ld_uns    = 1'b0;
    ld_ofs    = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
  endtask

  task automatic drive(input vec_t v);
    valid     = 1'b1;
    flush     = v.flush;
    wr_en_in  = v.wr;
    rd_in     = v.rd;
    sel       = v.sel;
    ld_size   = v.size;
    ld_uns    = v.uns;
    ld_ofs    = v.ofs;
    rsp_valid = v.rsp;
    rsp_data  = v.l1d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[15];
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    src_data = {CsrVal, Pc4Val, MemVal, AluVal};
    idle_inputs();

    //         flush wr  rd     sel   size  uns   ofs   rsp   l1d            exp_wr exp_data
    vecs[0]  = '{1'b0, 1'b1, 5'd5,  3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b1, AluVal};
    vecs[1]  = '{1'b0, 1'b1, 5'd6,  3'd2, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b1, Pc4Val};
    vecs[2]  = '{1'b0, 1'b1, 5'd7,  3'd3, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b1, CsrVal};
    vecs[3]  = '{1'b0, 1'b1, 5'd8,  3'd1, 2'd0, 1'b0, 2'd1, 1'b1, 32'h0000_8000, 1'b1, 32'hFFFF_FF80};
    vecs[4]  = '{1'b0, 1'b1, 5'd8,  3'd1, 2'd0, 1'b1, 2'd1, 1'b1, 32'h0000_8000, 1'b1, 32'h0000_0080};
    vecs[5]  = '{1'b0, 1'b1, 5'd9,  3'd1, 2'd1, 1'b0, 2'd2, 1'b1, 32'h8001_2345, 1'b1, 32'hFFFF_8001};
    vecs[6]  = '{1'b0, 1'b1, 5'd10, 3'd1, 2'd2, 1'b0, 2'd0, 1'b1, 32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF};
    vecs[7]  = '{1'b0, 1'b1, 5'd11, 3'd1, 2'd0, 1'b1, 2'd3, 1'b1, 32'h7F00_0000, 1'b1, 32'h0000_007F};
    vecs[8]  = '{1'b0, 1'b1, 5'd12, 3'd1, 2'd0, 1'b0, 2'd3, 1'b1, 32'h80AB_CDEF, 1'b1, 32'hFFFF_FF80};
    vecs[9]  = '{1'b0, 1'b1, 5'd0,  3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b0, AluVal};
    vecs[10] = '{1'b0, 1'b1, 5'd13, 3'd7, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 5'd14, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b0, AluVal};
    vecs[12] = '{1'b1, 1'b1, 5'd15, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 5'd16, 3'd1, 2'd1, 1'b1, 2'd0, 1'b1, 32'h0000_F00F, 1'b1, 32'h0000_F00F};
    vecs[14] = '{1'b0, 1'b1, 5'd17, 3'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hBAD0_BAD0, 1'b1, AluVal};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wr_en", 64'(wr_en_out), 64'd0);
    check("reset_rd", 64'(rd_out), 64'd0);
    check("reset_data", 64'(wb_data), 64'd0);
    check("reset_retire", 64'(retire), 64'd0);
    check("reset_ready", 64'(ready), 64'd1);
    rst_n = 1'b1;
    step();

    // Back-to-back table; a flushed entry must produce no write-back.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      check($sformatf("ready_vec%0d", i), 64'(ready), 64'd1);
      if (!vecs[i].flush) push_exp(vecs[i].exp_wr, vecs[i].rd, vecs[i].exp_data);
      step();
    end
    idle_inputs();
    step();

    // Half load, response three cycles after accept; a held instruction waits.
    v = '{1'b0, 1'b1, 5'd20, 3'd1, 2'd1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0};
    drive(v);
    check("stall_accept_ready", 64'(ready), 64'd1);
    step();
    v = '{1'b1, 1'b1, 5'd21, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0};
    drive(v);
    check("stall_ready_w1", 64'(ready), 64'd0);
    step();
    flush = 1'b0;
    check("stall_ready_w2", 64'(ready), 64'd0);
    step();
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_8765;
    ld_ofs    = 2'd2;
    ld_size   = 2'd0;
    ld_uns    = 1'b1;
    check("stall_ready_w3", 64'(ready), 64'd0);
    push_exp(1'b1, 5'd20, 32'hFFFF_8765);
    step();
    rsp_valid = 1'b0;
    check("stall_ready_after", 64'(ready), 64'd1);
    push_exp(1'b1, 5'd21, AluVal);
    step();
    idle_inputs();
    step();

    // Reset while a load is pending discards it.
    v = '{1'b0, 1'b1, 5'd22, 3'd1, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0};
    drive(v);
    step();
    idle_inputs();
    check("prewait_ready", 64'(ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_wr_en", 64'(wr_en_out), 64'd0);
    check("midwait_rst_rd", 64'(rd_out), 64'd0);
    check("midwait_rst_data", 64'(wb_data), 64'd0);
    check("midwait_rst_retire", 64'(retire), 64'd0);
    check("midwait_rst_ready", 64'(ready), 64'd1);
`ifdef KAMUS_WB_RETIRE_CNT_EN
    check("midwait_rst_cnt", retire_cnt, 64'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    rsp_valid = 1'b1;
    rsp_data  = 32'h5555_AAAA;
    step();
    rsp_valid = 1'b0;

    // Ten back-to-back retires after reset.
    for (int i = 1; i <= 10; i++) begin
      v = '{1'b0, 1'b1, 5'(i), 3'd2, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0};
      drive(v);
      push_exp(1'b1, 5'(i), Pc4Val);
      step();
    end
    idle_inputs();
    step();
`ifdef KAMUS_WB_RETIRE_CNT_EN
    check("retire_cnt_10", retire_cnt, 64'd10);
    dut.retire_cnt_q = '1;
    v = '{1'b0, 1'b1, 5'd3, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0};
    drive(v);
    push_exp(1'b1, 5'd3, AluVal);
    step();
    idle_inputs();
    check("retire_cnt_wrap", retire_cnt, 64'd0);
`endif
    repeat (3) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/kamus_wb_unit.md
# kamus_wb_unit

Parametrised write-back unit between the MEM stage and the register file. It holds the MEM/WB pipeline register and stalls on outstanding L1D load responses with a two-state FSM. It selects among NUM_SRC result sources, then aligns and sign- or zero-extends load data. It drives one registered register-file write per retired instruction and an optional retired-instruction counter.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- NUM_SRC, 4, number of write-back sources; index 0 = ALU, 1 = MEM (load), 2 = PC+4, 3 = CSR, higher indices free
- SEL_W, $clog2(NUM_SRC), width of the source select
- OFS_W, $clog2(XLEN/8), width of the byte offset
---
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- valid_i  in  1  MEM stage presents an instruction
- ready_o  out  1  unit can accept this cycle
- flush_i  in  1  kill the instruction presented this cycle
- regfile_wr_en_i  in  1  instruction writes rd
- rd_addr_i  in  5  destination register
- wb_mux_sel_i  in  SEL_W  source select
- src_data_i  in  NUM_SRC*XLEN  packed source data; slot k = bits [k*XLEN +: XLEN]
- ld_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (XLEN=64 only)
- ld_unsigned_i  in  1  zero-extend instead of sign-extend
- ld_offset_i  in  OFS_W  byte offset of the load within the L1D word
- l1d_rsp_valid_i  in  1  L1D read data valid
- l1d_rd_data_i  in  XLEN  L1D read data
- regfile_wr_en_o  out  1  register-file write strobe
- rd_addr_o  out  5  register-file write address
- wb_data_o  out  XLEN  register-file write data
- retire_o  out  1  one-cycle pulse per retired instruction
- retire_cnt_o  out  64  retired-instruction count (only with KAMUS_WB_RETIRE_CNT_EN)

## Operation
- Accept = valid_i && ready_o && !flush_i. ready_o = 1 in IDLE, 0 in WAIT.
- A load is wb_mux_sel_i == 1. Every other select is a non-load.
- FSM states are IDLE and WAIT.
  - IDLE, accept non-load: register rd, wr_en and selected data; stay IDLE.
  - IDLE, accept load with l1d_rsp_valid_i = 1: register the extended load data; stay IDLE.
  - IDLE, accept load with l1d_rsp_valid_i = 0: latch rd, wr_en, size, unsigned and offset; go to WAIT.
  - WAIT, l1d_rsp_valid_i = 1: register the extended data; go to IDLE.
  - WAIT, otherwise: hold all state.
- flush_i kills only the instruction presented in that cycle. It has no effect in WAIT, because the pending load is already committed.
- l1d_rsp_valid_i in IDLE with no load being accepted is ignored.
- Load extraction:
  - shifted = l1d_rd_data_i >> (offset*8).
  - Byte uses shifted[7:0], half uses [15:0], word uses [31:0], dword uses the full word.
  - The result is extended to XLEN: with the sign bit when ld_unsigned_i = 0, with zeros when ld_unsigned_i = 1.
  - Misalignment is trapped upstream and not checked here.
- wb_mux_sel_i >= NUM_SRC gives data 0. The write is still performed.
- rd_addr == 0 forces regfile_wr_en_o = 0. retire_o still pulses.
- retire_o pulses for every completed instruction, including instructions with wr_en = 0.

## Timing
- All outputs are registered.
- Reset values: regfile_wr_en_o = 0, rd_addr_o = 0, wb_data_o = 0, retire_o = 0, retire_cnt_o = 0, FSM = IDLE.
- Non-load latency is 1: accept at cycle N gives the write strobe at N+1.
- Load latency is 1 cycle after the cycle in which l1d_rsp_valid_i is sampled high, in either state.
- regfile_wr_en_o and retire_o are one-cycle pulses.
- rd_addr_o and wb_data_o hold their last value between pulses.
- Back-to-back non-loads retire one per cycle.
- A load that enters WAIT blocks the next instruction until the cycle after the response.
- Reset asserted mid-WAIT: the pending load is discarded and the FSM returns to IDLE.

## Configuration
- KAMUS_WB_RETIRE_CNT_EN defined: 64-bit retire_cnt_o increments on every retire_o pulse, wrapping at 2^64-1 to 0.
- Not defined: retire_cnt_o port and its counter are absent. retire_o is still present.

## Test plan
- Non-load, sel = 0, ALU slot = 0x1234_5678, rd = 5 -> at N+1: regfile_wr_en_o = 1, rd_addr_o = 5, wb_data_o = 0x1234_5678, retire_o = 1.
- Signed byte load, l1d_rd_data_i = 0x0000_8000, offset 1, response in the accept cycle -> wb_data_o = 0xFFFF_FF80. Same with ld_unsigned_i = 1 -> 0x0000_0080.
- Half load with response 3 cycles after accept -> ready_o = 0 for 3 cycles; the write comes 1 cycle after the response; a valid_i held during the stall is accepted the cycle after the response.
- flush_i with valid_i at N -> no write at N+1. Flush asserted during WAIT -> the load still writes back.
- rd = 0 with wr_en = 1 -> regfile_wr_en_o = 0, retire_o = 1. sel = 7 with NUM_SRC = 4 -> wb_data_o = 0.
- With KAMUS_WB_RETIRE_CNT_EN: 10 retires -> retire_cnt_o = 10. Counter preloaded to 2^64-1 plus one retire -> 0. rst_ni low mid-WAIT -> all outputs 0 and FSM in IDLE.
